hs_fifo_bridge: RTL

Parametrised successor to the single-stage handshake controller. Decouples a master (valid `ven` / ready `m_ready`) from a slave (valid `s_valid` / ready `ren`) through a DEPTH-entry FIFO of WIDTH-bit words. Sits between a data producer and a bus slave. Adds back-pressure, occupancy reporting and an explicit state machine.

---
 rtl/hs_pkg.sv | 29 ++
 rtl/hs_fifo_mem.sv | 55 +++++
 rtl/hs_fifo_bridge.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the hs_fifo_bridge handshake FIFO:
//   - hs_state_e    : 2-bit occupancy state (EMPTY / ACTIVE / FULL)
//   - STALL_W       : width of the optional stall counter
//   - stall_sat_inc : saturating increment used by the stall counter
// ---------------------------------------------------------------------------
package hs_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b01,
        FULL   = 2'b10
    } hs_state_e;

    localparam int STALL_W = 16;

    // Saturating increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [STALL_W-1:0] stall_sat_inc(input logic [STALL_W-1:0] v);
        logic [STALL_W-1:0] r;
        if (v == {STALL_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STALL_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// ---------------------------------------------------------------------------
// hs_fifo_mem
// WIDTH x DEPTH storage with one write port and one registered read port.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (clears read register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o holds its value when low
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// A write to the address being read in the same cycle is forwarded into the
// read register so a freshly written head word is visible one edge later.
// ---------------------------------------------------------------------------
module hs_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array write; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read with same-cycle write forwarding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= {WIDTH{1'b0}};
        end else if (re_i) begin
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hs_fifo_bridge.sv
// ---------------------------------------------------------------------------
// hs_fifo_bridge
// Valid/ready bridge between a master and a slave through a DEPTH-entry FIFO.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   ven       in   master valid          data_in  in  master data
//   m_ready   out  bridge can accept     s_valid  out head word valid
//   data_out  out  head word             ren      in  slave ready
//   level     out  occupancy 0..DEPTH    full/empty out occupancy flags
//   stall_cnt out  (only with HS_STATS_EN) saturating count of cycles
//                  with ven && !m_ready
// Every output is taken from a register, so there is no combinational path
// from ren to m_ready or from ven to s_valid.
// ---------------------------------------------------------------------------
module hs_fifo_bridge
    import hs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ven,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   m_ready,
    output logic                   s_valid,
    output logic [WIDTH-1:0]       data_out,
    input  logic                   ren,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
`ifdef HS_STATS_EN
    ,
    output logic [STALL_W-1:0]     stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    hs_state_e     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          rdy_q;
    logic          push_s, pop_s, rd_en_s;

    // rdy_q keeps m_ready low until the first edge after reset release.
    assign m_ready = rdy_q && (state_q != FULL);
    assign s_valid = (state_q != EMPTY);
    assign empty   = (state_q == EMPTY);
    assign full    = (state_q == FULL);
    assign level   = level_q;

    // Handshake decode, pointer/level/state next-state logic.
    always_comb begin
        push_s   = ven && m_ready;
        pop_s    = s_valid && ren;
        wr_ptr_d = wr_ptr_q + AW'(push_s);
        rd_ptr_d = rd_ptr_q + AW'(pop_s);
        level_d  = level_q;
        state_d  = state_q;

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1'b1);
            2'b01:   level_d = level_q - (AW+1)'(1'b1);
            default: level_d = level_q;
        endcase

        case (state_q)
            EMPTY: begin
                if (push_s) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ACTIVE: begin
                if (push_s && !pop_s && (level_q == (AW+1)'(DEPTH - 1))) begin
                    state_d = FULL;
                end else if (pop_s && !push_s && (level_q == (AW+1)'(1'b1))) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ACTIVE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Refresh the head register only when a word will be present, so
        // data_out keeps its last value once the FIFO drains.
        rd_en_s = (level_d != {(AW+1){1'b0}});
    end

    // Pointer, level, state and ready-enable registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EMPTY;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdy_q    <= 1'b1;
        end
    end

    // The read address is the next head position so data_out is ready
    // in the same cycle the pointer moves.
    hs_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (rd_en_s),
        .raddr_i (rd_ptr_d),
        .rdata_o (data_out)
    );

`ifdef HS_STATS_EN
    logic [STALL_W-1:0] stall_q;

    // Saturating count of cycles where the master is held off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= {STALL_W{1'b0}};
        end else if (ven && !m_ready) begin
            stall_q <= stall_sat_inc(stall_q);
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
